// File: rtl/gray_pkg.sv
// Shared Gray-code helpers used by the counter and the async FIFO pointer logic.
package gray_pkg;

    localparam int unsigned GRAY_MAX_W = 32;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Binary to Gray at the widest supported width; callers truncate to their width.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage : gray_pkg

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder: bit i is the XOR of all Gray bits at or above i.
module gray_to_bin #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Each output bit is an independent reduction, so no chained dependency inside a process.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[WIDTH-1:i];
    end

endmodule : gray_to_bin

// File: rtl/gray_counter.sv
// Registered up/down Gray counter with binary/Gray parallel load and wrap or saturate ends.
module gray_counter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0,
    parameter bit          WRAP      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_is_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             at_max,
    output logic             at_min,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(GRAY_MAX_W'(RST_BIN)));

    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             at_max_q, at_max_d;
    logic             at_min_q, at_min_d;
    logic             wrapped_q, wrapped_d;
    logic [WIDTH-1:0] load_bin;

    gray_to_bin #(
        .WIDTH (WIDTH)
    ) u_load_dec (
        .gray_i (load_val),
        .bin_o  (load_bin)
    );

    // Next count: load beats step beats hold; ends either wrap (with a pulse) or saturate.
    always_comb begin
        b_d       = b_q;
        wrapped_d = 1'b0;
        if (load) begin
            b_d = load_is_gray ? load_bin : load_val;
        end else if (en) begin
            if (dir_e'(up) == DIR_UP) begin
                if (b_q == ALL_ONES) begin
                    if (WRAP) begin
                        b_d       = '0;
                        wrapped_d = 1'b1;
                    end
                end else begin
                    b_d = b_q + WIDTH'(1);
                end
            end else begin
                if (b_q == '0) begin
                    if (WRAP) begin
                        b_d       = ALL_ONES;
                        wrapped_d = 1'b1;
                    end
                end else begin
                    b_d = b_q - WIDTH'(1);
                end
            end
        end
        // Gray is encoded from the next value so the flop output never passes through a decode.
        gray_d   = WIDTH'(bin2gray(GRAY_MAX_W'(b_d)));
        at_max_d = (b_d == ALL_ONES);
        at_min_d = (b_d == '0);
    end

    // All visible state updates on one edge; reset overrides load and step.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_q       <= RST_BIN;
            gray_q    <= RST_GRAY;
            at_max_q  <= (RST_BIN == ALL_ONES);
            at_min_q  <= (RST_BIN == '0);
            wrapped_q <= 1'b0;
        end else begin
            b_q       <= b_d;
            gray_q    <= gray_d;
            at_max_q  <= at_max_d;
            at_min_q  <= at_min_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign bin_out  = b_q;
    assign gray_out = gray_q;
    assign at_max   = at_max_q;
    assign at_min   = at_min_q;
    assign wrapped  = wrapped_q;

endmodule : gray_counter

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: wrapping, saturating and non-zero-reset instances share one stimulus.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, load, load_is_gray;
    logic [7:0] load_val;

    logic [7:0] w_gray, w_bin, s_gray, s_bin, r_gray, r_bin;
    logic       w_max, w_min, w_wrap, s_max, s_min, s_wrap, r_max, r_min, r_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(8), .RESET_VAL(0), .WRAP(1'b1)) dut_w (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_is_gray(load_is_gray),
        .load_val(load_val), .gray_out(w_gray), .bin_out(w_bin), .at_max(w_max),
        .at_min(w_min), .wrapped(w_wrap));

    gray_counter #(.WIDTH(8), .RESET_VAL(0), .WRAP(1'b0)) dut_s (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_is_gray(load_is_gray),
        .load_val(load_val), .gray_out(s_gray), .bin_out(s_bin), .at_max(s_max),
        .at_min(s_min), .wrapped(s_wrap));

    gray_counter #(.WIDTH(8), .RESET_VAL(32'h10), .WRAP(1'b1)) dut_r (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_is_gray(load_is_gray),
        .load_val(load_val), .gray_out(r_gray), .bin_out(r_bin), .at_max(r_max),
        .at_min(r_min), .wrapped(r_wrap));

    typedef struct {
        logic       rst, load, lg, en, up;
        logic [7:0] val;
        logic [7:0] exp_bin, exp_gray;
        logic       exp_max, exp_min, exp_wrap;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mkv(input logic r, input logic ld, input logic lg, input logic e,
                                 input logic u, input logic [7:0] v, input logic [7:0] eb,
                                 input logic [7:0] eg, input logic emx, input logic emn,
                                 input logic ew);
        vec_t t;
        t.rst = r; t.load = ld; t.lg = lg; t.en = e; t.up = u; t.val = v;
        t.exp_bin = eb; t.exp_gray = eg; t.exp_max = emx; t.exp_min = emn; t.exp_wrap = ew;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ld, input logic lg, input logic e,
                         input logic u, input logic [7:0] v);
        rst = r; load = ld; load_is_gray = lg; en = e; up = u; load_val = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] prev_gray;
        logic [7:0] exp_b;

        //              rst  ld   lg   en   up   val    bin    gray   max  min  wrap
        vecs[0]  = mkv(1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h00, 8'h00, 1'b0,1'b1,1'b0);
        vecs[1]  = mkv(1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h00, 8'h00, 1'b0,1'b1,1'b0);
        vecs[2]  = mkv(1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h00, 8'h00, 1'b0,1'b1,1'b0);
        vecs[3]  = mkv(1'b0,1'b1,1'b0,1'b0,1'b0,8'hBB, 8'hBB, 8'hE6, 1'b0,1'b0,1'b0);
        vecs[4]  = mkv(1'b0,1'b1,1'b1,1'b0,1'b0,8'hE6, 8'hBB, 8'hE6, 1'b0,1'b0,1'b0);
        vecs[5]  = mkv(1'b0,1'b1,1'b0,1'b0,1'b0,8'h7F, 8'h7F, 8'h40, 1'b0,1'b0,1'b0);
        vecs[6]  = mkv(1'b0,1'b0,1'b0,1'b1,1'b1,8'h00, 8'h80, 8'hC0, 1'b0,1'b0,1'b0);
        vecs[7]  = mkv(1'b0,1'b1,1'b0,1'b0,1'b0,8'hFF, 8'hFF, 8'h80, 1'b1,1'b0,1'b0);
        vecs[8]  = mkv(1'b0,1'b0,1'b0,1'b1,1'b1,8'h00, 8'h00, 8'h00, 1'b0,1'b1,1'b1);
        vecs[9]  = mkv(1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h00, 8'h00, 1'b0,1'b1,1'b0);
        vecs[10] = mkv(1'b0,1'b0,1'b0,1'b1,1'b0,8'h00, 8'hFF, 8'h80, 1'b1,1'b0,1'b1);
        vecs[11] = mkv(1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 8'hFF, 8'h80, 1'b1,1'b0,1'b0);
        vecs[12] = mkv(1'b0,1'b0,1'b0,1'b1,1'b0,8'h00, 8'hFE, 8'h81, 1'b0,1'b0,1'b0);
        vecs[13] = mkv(1'b0,1'b1,1'b0,1'b1,1'b1,8'h05, 8'h05, 8'h07, 1'b0,1'b0,1'b0);
        vecs[14] = mkv(1'b0,1'b0,1'b0,1'b1,1'b1,8'h00, 8'h06, 8'h05, 1'b0,1'b0,1'b0);
        vecs[15] = mkv(1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h06, 8'h05, 1'b0,1'b0,1'b0);

        rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_is_gray = 1'b0; load_val = 8'h00;

        // Table vectors on the wrapping instance.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].load, vecs[i].lg, vecs[i].en, vecs[i].up, vecs[i].val);
            check($sformatf("vec%0d bin", i),  32'(w_bin),  32'(vecs[i].exp_bin));
            check($sformatf("vec%0d gray", i), 32'(w_gray), 32'(vecs[i].exp_gray));
            check($sformatf("vec%0d at_max", i), 32'(w_max), 32'(vecs[i].exp_max));
            check($sformatf("vec%0d at_min", i), 32'(w_min), 32'(vecs[i].exp_min));
            check($sformatf("vec%0d wrapped", i), 32'(w_wrap), 32'(vecs[i].exp_wrap));
        end

        // Full up sweep: exactly one Gray bit changes per step, wrap pulse on the last one.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        prev_gray = w_gray;
        exp_b = 8'h00;
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
            exp_b = exp_b + 8'd1;
            check($sformatf("sweep%0d bin", i), 32'(w_bin), 32'(exp_b));
            check($sformatf("sweep%0d gray_bits", i), 32'($countones(w_gray ^ prev_gray)), 32'd1);
            check($sformatf("sweep%0d wrapped", i), 32'(w_wrap), (i == 255) ? 32'd1 : 32'd0);
            prev_gray = w_gray;
        end

        // Saturating instance: bottom end holds.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            check($sformatf("sat_lo%0d bin", i), 32'(s_bin), 32'h00);
            check($sformatf("sat_lo%0d at_min", i), 32'(s_min), 32'd1);
            check($sformatf("sat_lo%0d wrapped", i), 32'(s_wrap), 32'd0);
        end
        // Saturating instance: top end holds.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
            check($sformatf("sat_hi%0d bin", i), 32'(s_bin), 32'hFF);
            check($sformatf("sat_hi%0d gray", i), 32'(s_gray), 32'h80);
            check($sformatf("sat_hi%0d at_max", i), 32'(s_max), 32'd1);
            check($sformatf("sat_hi%0d wrapped", i), 32'(s_wrap), 32'd0);
        end

        // Non-zero reset value, then reset overriding load and step mid-count.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("rv_reset bin", 32'(r_bin), 32'h10);
        check("rv_reset gray", 32'(r_gray), 32'h18);
        check("rv_reset at_min", 32'(r_min), 32'd0);
        for (int i = 0; i < 21; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        check("rv_count bin", 32'(r_bin), 32'h25);
        check("rv_count gray", 32'(r_gray), 32'h37);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hAA);
        check("rv_rst_over bin", 32'(r_bin), 32'h10);
        check("rv_rst_over gray", 32'(r_gray), 32'h18);
        check("rv_rst_over wrapped", 32'(r_wrap), 32'd0);
        check("rv_rst_over at_max", 32'(r_max), 32'd0);
        check("wrap_rst_over bin", 32'(w_bin), 32'h00);
        check("wrap_rst_over at_min", 32'(w_min), 32'd1);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_gray_counter
